// File: rtl/vpu_cmd_issuer.sv
// Command issuer toward vector_unit: buffers controller commands in a small FIFO
// and keeps at most one outstanding on cmd/cmd_valid/cmd_ready until cmd_done.
module vpu_cmd_issuer #(
    parameter int CMD_WIDTH = 128,
    parameter int DEPTH     = 4,
    parameter int TIMEOUT   = 1024,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CMD_WIDTH-1:0] in_cmd,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [CMD_WIDTH-1:0] cmd,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    input  logic                 cmd_done,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] issued_count,
    output logic [CNT_WIDTH-1:0] done_count,
    output logic                 err_timeout,
    output logic                 err_spurious,
    input  logic                 clear_err
);

    localparam int AW  = $clog2(DEPTH);
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HALT} state_t;

    logic [CMD_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    state_t               state_q, state_d;
    logic                 cmd_valid_q, cmd_valid_d;
    logic [CNT_WIDTH-1:0] issued_q, issued_d, done_q, done_d;
    logic [WDW-1:0]       wd_q, wd_d;
    logic                 err_to_q, err_to_d, err_sp_q, err_sp_d;
    logic                 full, empty, push, pop, timeout_hit, spurious;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = in_valid && !full;
    assign pop   = cmd_valid_q && cmd_ready;

    assign in_ready     = !full;
    assign cmd          = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
    assign cmd_valid    = cmd_valid_q;
    assign busy         = (state_q != S_IDLE) || !empty;
    assign issued_count = issued_q;
    assign done_count   = done_q;
    assign err_timeout  = err_to_q;
    assign err_spurious = err_sp_q;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d    = rd_ptr_q + (AW+1)'(pop);
        issued_d    = issued_q + CNT_WIDTH'(pop);
        done_d      = done_q;
        wd_d        = wd_q;
        timeout_hit = 1'b0;
        spurious    = 1'b0;
        case (state_q)
            S_IDLE: begin
                spurious = cmd_done;
                if (!empty) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                spurious = cmd_done;
                if (cmd_ready) begin
                    state_d = S_WAIT;
                    wd_d    = '0;
                end
            end
            S_WAIT: begin
                wd_d = wd_q + WDW'(1);
                // A done on the expiry edge completes normally.
                if (cmd_done) begin
                    done_d  = done_q + CNT_WIDTH'(1);
                    state_d = empty ? S_IDLE : S_ISSUE;
                end else if (TIMEOUT != 0 && wd_q == WD_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = S_HALT;
                end
            end
            S_HALT: begin
                spurious = cmd_done;
                if (clear_err) begin
                    state_d = S_IDLE;
                    wd_d    = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        cmd_valid_d = (state_d == S_ISSUE);
        err_to_d    = (err_to_q && !clear_err) || timeout_hit;
        err_sp_d    = (err_sp_q && !clear_err) || spurious;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cmd_valid_q <= 1'b0;
            issued_q    <= '0;
            done_q      <= '0;
            wd_q        <= '0;
            err_to_q    <= 1'b0;
            err_sp_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cmd_valid_q <= cmd_valid_d;
            issued_q    <= issued_d;
            done_q      <= done_d;
            wd_q        <= wd_d;
            err_to_q    <= err_to_d;
            err_sp_q    <= err_sp_d;
        end
    end

    // Storage needs no reset: cmd is masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= in_cmd;
    end

endmodule

// File: tb/tb_vpu_cmd_issuer.sv
// Directed self-checking bench for vpu_cmd_issuer (watchdog shortened to 8 cycles).
module tb_vpu_cmd_issuer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] in_cmd;
    logic         in_valid, in_ready;
    logic [127:0] cmd;
    logic         cmd_valid, cmd_ready, cmd_done, busy;
    logic [15:0]  issued_count, done_count;
    logic         err_timeout, err_spurious, clear_err;

    int n_chk = 0;
    int n_err = 0;

    vpu_cmd_issuer #(.CMD_WIDTH(128), .DEPTH(4), .TIMEOUT(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_cmd(in_cmd), .in_valid(in_valid), .in_ready(in_ready),
        .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_done(cmd_done),
        .busy(busy), .issued_count(issued_count), .done_count(done_count),
        .err_timeout(err_timeout), .err_spurious(err_spurious), .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] op(input logic [7:0] o, input logic [7:0] a);
        return {o, a, 112'h0};
    endfunction

    task automatic push1(input logic [127:0] w);
        in_cmd   = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_cmd = '0; in_valid = 0; cmd_ready = 0; cmd_done = 0; clear_err = 0;
        repeat (2) tick();
        chk("rst_valid", 128'(cmd_valid), 128'd0);
        chk("rst_cmd", cmd, 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_counts", {issued_count, done_count}, 128'd0);
        chk("rst_errs", {err_timeout, err_spurious}, 128'd0);
        rst_n = 1'b1;
        tick();

        // single command, VPU always ready
        cmd_ready = 1'b1;
        push1(op(8'h02, 8'h34));
        chk("s_valid_n", 128'(cmd_valid), 128'd0);
        chk("s_busy", 128'(busy), 128'd1);
        tick();
        chk("s_valid", 128'(cmd_valid), 128'd1);
        chk("s_cmd", cmd, op(8'h02, 8'h34));
        tick();
        chk("s_valid_drop", 128'(cmd_valid), 128'd0);
        chk("s_issued", 128'(issued_count), 128'd1);
        tick(); tick();
        cmd_done = 1'b1; tick(); cmd_done = 1'b0;
        chk("s_done", 128'(done_count), 128'd1);
        chk("s_idle", 128'(busy), 128'd0);
        chk("s_cmd_empty", cmd, 128'd0);
        chk("s_errs", {err_timeout, err_spurious}, 128'd0);

        // backpressure: ready low 5 cycles
        cmd_ready = 1'b0;
        push1(op(8'h11, 8'h22));
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 128'(cmd_valid), 128'd1);
            chk("bp_cmd", cmd, op(8'h11, 8'h22));
            tick();
        end
        chk("bp_no_accept", 128'(issued_count), 128'd1);
        cmd_ready = 1'b1;
        chk("bp_valid6", 128'(cmd_valid), 128'd1);
        chk("bp_cmd6", cmd, op(8'h11, 8'h22));
        tick();
        chk("bp_issued", 128'(issued_count), 128'd2);
        chk("bp_valid_drop", 128'(cmd_valid), 128'd0);
        cmd_done = 1'b1; tick(); cmd_done = 1'b0;
        chk("bp_done", 128'(done_count), 128'd2);

        // fill with VPU stalled, then drain back-to-back
        cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("f_in_ready", 128'(in_ready), 128'd1);
            push1(op(8'h30 + 8'(i), 8'h00));
        end
        chk("f_full", 128'(in_ready), 128'd0);
        in_cmd = op(8'h34, 8'h00); in_valid = 1'b1;
        tick();
        chk("f_still_full", 128'(in_ready), 128'd0);
        chk("f_head", cmd, op(8'h30, 8'h00));
        cmd_ready = 1'b1;
        tick();
        chk("f_pop_free", 128'(in_ready), 128'd1);
        chk("f_issued0", 128'(issued_count), 128'd3);
        tick();
        in_valid = 1'b0;
        chk("f_refull", 128'(in_ready), 128'd0);
        cmd_done = 1'b1; tick(); cmd_done = 1'b0;
        for (int k = 1; k < 5; k++) begin
            chk("f_valid", 128'(cmd_valid), 128'd1);
            chk("f_order", cmd, op(8'h30 + 8'(k), 8'h00));
            tick();
            chk("f_gap", 128'(cmd_valid), 128'd0);
            tick();
            cmd_done = 1'b1; tick(); cmd_done = 1'b0;
        end
        chk("f_last_idle", 128'(cmd_valid), 128'd0);
        chk("f_busy", 128'(busy), 128'd0);
        chk("f_issued", 128'(issued_count), 128'd7);
        chk("f_done", 128'(done_count), 128'd7);

        // watchdog: no done for 8 cycles in S_WAIT
        cmd_ready = 1'b0;
        push1(op(8'h40, 8'h00));
        push1(op(8'h41, 8'h00));
        cmd_ready = 1'b1;
        chk("w_head", cmd, op(8'h40, 8'h00));
        tick();
        repeat (7) tick();
        chk("w_not_yet", 128'(err_timeout), 128'd0);
        tick();
        chk("w_expired", 128'(err_timeout), 128'd1);
        repeat (3) begin
            chk("w_halt_noissue", 128'(cmd_valid), 128'd0);
            tick();
        end
        chk("w_halt_issued", 128'(issued_count), 128'd8);
        chk("w_halt_busy", 128'(busy), 128'd1);
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        chk("w_cleared", 128'(err_timeout), 128'd0);
        tick();
        chk("w_resume", 128'(cmd_valid), 128'd1);
        chk("w_resume_cmd", cmd, op(8'h41, 8'h00));
        tick();
        chk("w_issued", 128'(issued_count), 128'd9);
        cmd_done = 1'b1; tick(); cmd_done = 1'b0;
        chk("w_done", 128'(done_count), 128'd8);
        chk("w_idle", 128'(busy), 128'd0);

        // spurious done in S_IDLE
        cmd_done = 1'b1; tick(); cmd_done = 1'b0;
        chk("sp_flag", 128'(err_spurious), 128'd1);
        chk("sp_done_cnt", 128'(done_count), 128'd8);
        chk("sp_idle", 128'(busy), 128'd0);
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        chk("sp_clear", 128'(err_spurious), 128'd0);

        // reset while waiting with two queued entries
        cmd_ready = 1'b0;
        push1(op(8'h50, 8'h00));
        push1(op(8'h51, 8'h00));
        push1(op(8'h52, 8'h00));
        cmd_ready = 1'b1;
        tick();
        chk("r_pre_issued", 128'(issued_count), 128'd10);
        rst_n = 1'b0;
        #1;
        chk("r_valid", 128'(cmd_valid), 128'd0);
        chk("r_counts", {issued_count, done_count}, 128'd0);
        chk("r_busy", 128'(busy), 128'd0);
        chk("r_in_ready", 128'(in_ready), 128'd1);
        tick();
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            chk("r_quiet", 128'({cmd_valid, busy}), 128'd0);
        end
        push1(op(8'h60, 8'h00));
        tick();
        chk("r_new_valid", 128'(cmd_valid), 128'd1);
        chk("r_new_cmd", cmd, op(8'h60, 8'h00));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
